// File: rtl/tl_buffer_param.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tl_buffer_param
// Purpose : TileLink-style channel buffer. The A channel (requests flowing
//           downstream) and the D channel (responses flowing back upstream)
//           each pass through an independent circular FIFO whose depth,
//           flow-through and pipelined-full behaviour are set by parameters.
//           A depth of 0 turns a channel into plain wires.
// Ports   : clock, reset             - single clock, async active-high reset
//           a_in_*  (valid/ready/bits) - A channel from upstream
//           a_out_* (valid/ready/bits) - A channel to downstream
//           d_in_*  (valid/ready/bits) - D channel from downstream
//           d_out_* (valid/ready/bits) - D channel back to upstream
//           a_count, d_count         - current occupancy of each queue
//           idle                     - both queues empty
// ---------------------------------------------------------------------------

// Single-channel circular queue used for both A and D.
// Ports: clock/reset, in_* handshake, out_* handshake, count (occupancy),
// empty (no stored beats).
module tl_buffer_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bits,
  output logic [3:0]       count,
  output logic             empty
);

  if (DEPTH == 0) begin : g_wire
    // Pure passthrough; handshakes are still held off while reset is high.
    assign out_valid = in_valid && !reset;
    assign in_ready  = out_ready && !reset;
    assign out_bits  = in_bits;
    assign count     = 4'd0;
    assign empty     = 1'b1;
  end else begin : g_fifo
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0]    enq_ptr_q, enq_ptr_d;
    logic [PW-1:0]    deq_ptr_q, deq_ptr_d;
    logic             maybe_full_q, maybe_full_d;
    logic [WIDTH-1:0] ram_q [DEPTH];

    logic ptr_match, is_empty, is_full, bypass, do_enq, do_deq;

    always_comb begin
      ptr_match = (enq_ptr_q == deq_ptr_q);
      is_empty  = ptr_match && !maybe_full_q;
      is_full   = ptr_match && maybe_full_q;
      bypass    = (FLOW != 0) && is_empty;

      out_valid = !reset && (!is_empty || (bypass && in_valid));
      in_ready  = !reset && (!is_full || ((PIPE != 0) && out_ready));
      out_bits  = bypass ? in_bits : ram_q[deq_ptr_q];
      empty     = is_empty;

      // A beat that flows straight through an empty queue never touches
      // storage, so neither pointer moves for it.
      do_enq = in_valid && in_ready && !(bypass && out_ready);
      do_deq = !reset && !is_empty && out_ready;

      enq_ptr_d = enq_ptr_q;
      if (do_enq) begin
        enq_ptr_d = (enq_ptr_q == LAST) ? '0 : enq_ptr_q + 1'b1;
      end

      deq_ptr_d = deq_ptr_q;
      if (do_deq) begin
        deq_ptr_d = (deq_ptr_q == LAST) ? '0 : deq_ptr_q + 1'b1;
      end

      // Equal pointers are ambiguous; the flag remembers which side moved last.
      maybe_full_d = maybe_full_q;
      if (do_enq != do_deq) begin
        maybe_full_d = do_enq;
      end

      if (is_full) begin
        count = 4'(DEPTH);
      end else if (enq_ptr_q >= deq_ptr_q) begin
        count = 4'(enq_ptr_q - deq_ptr_q);
      end else begin
        count = 4'(DEPTH) - 4'(deq_ptr_q - enq_ptr_q);
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        enq_ptr_q    <= '0;
        deq_ptr_q    <= '0;
        maybe_full_q <= 1'b0;
      end else begin
        enq_ptr_q    <= enq_ptr_d;
        deq_ptr_q    <= deq_ptr_d;
        maybe_full_q <= maybe_full_d;
      end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
      if (do_enq) begin
        ram_q[enq_ptr_q] <= in_bits;
      end
    end
  end

endmodule

module tl_buffer_param #(
  parameter int ADDR_W  = 31,
  parameter int SRC_W   = 5,
  parameter int SZ_W    = 3,
  parameter int DATA_W  = 32,
  parameter int DEPTH_A = 2,
  parameter int DEPTH_D = 2,
  parameter int FLOW_A  = 0,
  parameter int FLOW_D  = 0,
  parameter int PIPE_A  = 0,
  parameter int PIPE_D  = 0,
  localparam int AW = 3 + 3 + SZ_W + SRC_W + ADDR_W + DATA_W / 8 + DATA_W + 1,
  localparam int DW = 3 + 2 + SZ_W + SRC_W + 1 + 1 + DATA_W + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_in_valid,
  output logic          a_in_ready,
  input  logic [AW-1:0] a_in_bits,
  output logic          a_out_valid,
  input  logic          a_out_ready,
  output logic [AW-1:0] a_out_bits,
  input  logic          d_in_valid,
  output logic          d_in_ready,
  input  logic [DW-1:0] d_in_bits,
  output logic          d_out_valid,
  input  logic          d_out_ready,
  output logic [DW-1:0] d_out_bits,
  output logic [3:0]    a_count,
  output logic [3:0]    d_count,
  output logic          idle
);

  logic a_empty, d_empty;

  tl_buffer_queue #(
    .WIDTH(AW), .DEPTH(DEPTH_A), .FLOW(FLOW_A), .PIPE(PIPE_A)
  ) u_a_queue (
    .clock    (clock),
    .reset    (reset),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .in_bits  (a_in_bits),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .out_bits (a_out_bits),
    .count    (a_count),
    .empty    (a_empty)
  );

  tl_buffer_queue #(
    .WIDTH(DW), .DEPTH(DEPTH_D), .FLOW(FLOW_D), .PIPE(PIPE_D)
  ) u_d_queue (
    .clock    (clock),
    .reset    (reset),
    .in_valid (d_in_valid),
    .in_ready (d_in_ready),
    .in_bits  (d_in_bits),
    .out_valid(d_out_valid),
    .out_ready(d_out_ready),
    .out_bits (d_out_bits),
    .count    (d_count),
    .empty    (d_empty)
  );

  assign idle = a_empty && d_empty;

endmodule

// File: tb/tb_tl_buffer_param.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_tl_buffer_param
// Purpose : self-checking bench for tl_buffer_param. Two instances cover the
//           interesting parameter corners:
//             dut0: A depth 2 pipelined, D depth 4 with flow-through
//             dut1: A passthrough (depth 0), D depth 1 pipelined
//           Each channel is mirrored by a plain queue of accepted beats; the
//           monitor derives ready/valid/count/payload from that queue alone.
// ---------------------------------------------------------------------------
module tb_tl_buffer_param;

  localparam int ADDR_W = 31;
  localparam int SRC_W  = 5;
  localparam int SZ_W   = 3;
  localparam int DATA_W = 32;
  localparam int AW     = 3 + 3 + SZ_W + SRC_W + ADDR_W + DATA_W / 8 + DATA_W + 1;
  localparam int DW     = 3 + 2 + SZ_W + SRC_W + 1 + 1 + DATA_W + 1;
  localparam int A_LO   = DATA_W / 8 + DATA_W + 1;

  typedef logic [127:0] beat_t;
  typedef beat_t beat_q_t[$];

  beat_q_t mq[4];
  int total = 0;
  int bad   = 0;

  logic clock = 1'b0;
  logic rst   = 1'b0;

  always #5 clock = ~clock;

  logic          a0_in_valid, a0_in_ready, a0_out_valid, a0_out_ready;
  logic [AW-1:0] a0_in_bits, a0_out_bits;
  logic          d0_in_valid, d0_in_ready, d0_out_valid, d0_out_ready;
  logic [DW-1:0] d0_in_bits, d0_out_bits;
  logic [3:0]    a0_count, d0_count;
  logic          idle0;

  logic          a1_in_valid, a1_in_ready, a1_out_valid, a1_out_ready;
  logic [AW-1:0] a1_in_bits, a1_out_bits;
  logic          d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
  logic [DW-1:0] d1_in_bits, d1_out_bits;
  logic [3:0]    a1_count, d1_count;
  logic          idle1;

  tl_buffer_param #(
    .DEPTH_A(2), .DEPTH_D(4), .FLOW_A(0), .FLOW_D(1), .PIPE_A(1), .PIPE_D(0)
  ) dut0 (
    .clock(clock), .reset(rst),
    .a_in_valid(a0_in_valid), .a_in_ready(a0_in_ready), .a_in_bits(a0_in_bits),
    .a_out_valid(a0_out_valid), .a_out_ready(a0_out_ready), .a_out_bits(a0_out_bits),
    .d_in_valid(d0_in_valid), .d_in_ready(d0_in_ready), .d_in_bits(d0_in_bits),
    .d_out_valid(d0_out_valid), .d_out_ready(d0_out_ready), .d_out_bits(d0_out_bits),
    .a_count(a0_count), .d_count(d0_count), .idle(idle0)
  );

  tl_buffer_param #(
    .DEPTH_A(0), .DEPTH_D(1), .FLOW_A(1), .FLOW_D(0), .PIPE_A(1), .PIPE_D(1)
  ) dut1 (
    .clock(clock), .reset(rst),
    .a_in_valid(a1_in_valid), .a_in_ready(a1_in_ready), .a_in_bits(a1_in_bits),
    .a_out_valid(a1_out_valid), .a_out_ready(a1_out_ready), .a_out_bits(a1_out_bits),
    .d_in_valid(d1_in_valid), .d_in_ready(d1_in_ready), .d_in_bits(d1_in_bits),
    .d_out_valid(d1_out_valid), .d_out_ready(d1_out_ready), .d_out_bits(d1_out_bits),
    .a_count(a1_count), .d_count(d1_count), .idle(idle1)
  );

  function automatic beat_t randBeat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [AW-1:0] mkA(input logic [ADDR_W-1:0] addr);
    beat_t b;
    logic [AW-1:0] r;
    b = randBeat();
    r = b[AW-1:0];
    r[A_LO +: ADDR_W] = addr;
    return r;
  endfunction

  function automatic logic [DW-1:0] mkD(input logic [DATA_W-1:0] data);
    beat_t b;
    logic [DW-1:0] r;
    b = randBeat();
    r = b[DW-1:0];
    r[1 +: DATA_W] = data;
    return r;
  endfunction

  task automatic checkEq(input string name, input beat_t act, input beat_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares one channel against its beat queue, then advances the queue by
  // whatever transfers the upcoming clock edge will perform.
  task automatic checkOutput(input int ch, input string nm, input int depth,
                             input int flow, input int pipe,
                             input logic in_v, input logic in_r,
                             input logic out_v, input logic out_r,
                             input beat_t in_b, input beat_t out_b,
                             input logic [3:0] cnt);
    int n;
    logic exp_in_r, exp_out_v, fin, fout;
    beat_t exp_b;
    if (depth == 0) begin
      checkEq({nm, "_in_ready"}, beat_t'(in_r), beat_t'(out_r));
      checkEq({nm, "_out_valid"}, beat_t'(out_v), beat_t'(in_v));
      checkEq({nm, "_count"}, beat_t'(cnt), beat_t'(0));
      if (in_v) checkEq({nm, "_bits"}, out_b, in_b);
    end else begin
      n = mq[ch].size();
      exp_in_r  = (n < depth) || ((pipe != 0) && out_r);
      exp_out_v = (n > 0) || ((flow != 0) && in_v);
      checkEq({nm, "_in_ready"}, beat_t'(in_r), beat_t'(exp_in_r));
      checkEq({nm, "_out_valid"}, beat_t'(out_v), beat_t'(exp_out_v));
      checkEq({nm, "_count"}, beat_t'(cnt), beat_t'(n));
      if (exp_out_v) begin
        exp_b = (n > 0) ? mq[ch][0] : in_b;
        checkEq({nm, "_bits"}, out_b, exp_b);
      end
      fin  = in_v && exp_in_r;
      fout = exp_out_v && out_r;
      if (!(n == 0 && fin && fout)) begin
        if (fout) void'(mq[ch].pop_front());
        if (fin) mq[ch].push_back(in_b);
      end
    end
  endtask

  // Monitor: samples on the falling edge, halfway between input changes and
  // the next active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (rst) begin
        checkEq("rst_a0_in_ready", beat_t'(a0_in_ready), beat_t'(0));
        checkEq("rst_a0_out_valid", beat_t'(a0_out_valid), beat_t'(0));
        checkEq("rst_d0_in_ready", beat_t'(d0_in_ready), beat_t'(0));
        checkEq("rst_d0_out_valid", beat_t'(d0_out_valid), beat_t'(0));
        checkEq("rst_a1_out_valid", beat_t'(a1_out_valid), beat_t'(0));
        checkEq("rst_a1_in_ready", beat_t'(a1_in_ready), beat_t'(0));
        checkEq("rst_d1_out_valid", beat_t'(d1_out_valid), beat_t'(0));
        checkEq("rst_counts", beat_t'({a0_count, d0_count, a1_count, d1_count}), beat_t'(0));
        checkEq("rst_idle", beat_t'({idle0, idle1}), beat_t'(3));
        for (int i = 0; i < 4; i++) mq[i].delete();
      end else begin
        checkEq("idle0", beat_t'(idle0), beat_t'(mq[0].size() == 0 && mq[1].size() == 0));
        checkEq("idle1", beat_t'(idle1), beat_t'(mq[3].size() == 0));
        checkOutput(0, "a0", 2, 0, 1, a0_in_valid, a0_in_ready, a0_out_valid, a0_out_ready,
                    beat_t'(a0_in_bits), beat_t'(a0_out_bits), a0_count);
        checkOutput(1, "d0", 4, 1, 0, d0_in_valid, d0_in_ready, d0_out_valid, d0_out_ready,
                    beat_t'(d0_in_bits), beat_t'(d0_out_bits), d0_count);
        checkOutput(2, "a1", 0, 1, 1, a1_in_valid, a1_in_ready, a1_out_valid, a1_out_ready,
                    beat_t'(a1_in_bits), beat_t'(a1_out_bits), a1_count);
        checkOutput(3, "d1", 1, 0, 1, d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready,
                    beat_t'(d1_in_bits), beat_t'(d1_out_bits), d1_count);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One cycle of random traffic on every channel; dut1's A sink toggles.
  task automatic applyStimulus(input int cyc);
    beat_t b;
    b = randBeat(); a0_in_bits = b[AW-1:0];
    b = randBeat(); d0_in_bits = b[DW-1:0];
    b = randBeat(); a1_in_bits = b[AW-1:0];
    b = randBeat(); d1_in_bits = b[DW-1:0];
    a0_in_valid  = 1'($urandom_range(0, 1));
    d0_in_valid  = 1'($urandom_range(0, 3) != 0);
    a1_in_valid  = 1'($urandom_range(0, 1));
    d1_in_valid  = 1'($urandom_range(0, 1));
    a0_out_ready = 1'($urandom_range(0, 2) != 0);
    d0_out_ready = 1'($urandom_range(0, 2) == 0);
    a1_out_ready = 1'(cyc % 2);
    d1_out_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    a0_in_valid = 0; a0_in_bits = '0; a0_out_ready = 0;
    d0_in_valid = 0; d0_in_bits = '0; d0_out_ready = 0;
    a1_in_valid = 0; a1_in_bits = '0; a1_out_ready = 0;
    d1_in_valid = 0; d1_in_bits = '0; d1_out_ready = 0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;

    // Three A beats into a two-entry queue with the sink stalled.
    a0_in_valid = 1'b1; a0_in_bits = mkA(31'h10); a0_out_ready = 1'b0;
    step(); a0_in_bits = mkA(31'h20);
    step(); a0_in_bits = mkA(31'h30);
    #2;
    checkEq("a_full_in_ready", beat_t'(a0_in_ready), beat_t'(0));
    checkEq("a_full_count", beat_t'(a0_count), beat_t'(2));
    step(); a0_out_ready = 1'b1;
    #2;
    checkEq("a_pipe_in_ready", beat_t'(a0_in_ready), beat_t'(1));
    checkEq("a_first_addr", beat_t'(a0_out_bits[A_LO +: ADDR_W]), beat_t'(32'h10));
    step(); a0_in_valid = 1'b0;
    #2;
    checkEq("a_pipe_count_held", beat_t'(a0_count), beat_t'(2));
    checkEq("a_second_addr", beat_t'(a0_out_bits[A_LO +: ADDR_W]), beat_t'(32'h20));
    step();
    #2;
    checkEq("a_third_addr", beat_t'(a0_out_bits[A_LO +: ADDR_W]), beat_t'(32'h30));
    checkEq("a_drain_count", beat_t'(a0_count), beat_t'(1));
    step(); a0_out_ready = 1'b0;

    // Flow-through on an empty D queue.
    d0_in_valid = 1'b1; d0_in_bits = mkD(32'hDEADBEEF); d0_out_ready = 1'b1;
    #2;
    checkEq("d_flow_valid", beat_t'(d0_out_valid), beat_t'(1));
    checkEq("d_flow_data", beat_t'(d0_out_bits[1 +: DATA_W]), beat_t'(32'hDEADBEEF));
    checkEq("d_flow_count", beat_t'(d0_count), beat_t'(0));

    // Two beats queued, then an asynchronous reset between edges.
    step(); d0_out_ready = 1'b0; d0_in_bits = mkD(32'h11111111);
    step(); d0_in_bits = mkD(32'h22222222);
    step(); d0_in_valid = 1'b0;
    #2;
    checkEq("d_queued_count", beat_t'(d0_count), beat_t'(2));
    rst = 1'b1;
    #1;
    checkEq("async_rst_d_count", beat_t'(d0_count), beat_t'(0));
    checkEq("async_rst_d_valid", beat_t'(d0_out_valid), beat_t'(0));
    checkEq("async_rst_d_in_ready", beat_t'(d0_in_ready), beat_t'(0));
    checkEq("async_rst_idle", beat_t'(idle0), beat_t'(1));
    step(); rst = 1'b0;

    // Random traffic with back-pressure; the monitor checks every cycle.
    for (int cyc = 0; cyc < 400; cyc++) begin
      applyStimulus(cyc);
      step();
    end

    a0_in_valid = 0; d0_in_valid = 0; a1_in_valid = 0; d1_in_valid = 0;
    a0_out_ready = 1; d0_out_ready = 1; a1_out_ready = 1; d1_out_ready = 1;
    repeat (8) step();
    checkEq("final_idle0", beat_t'(idle0), beat_t'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
